// File: rtl/decoder_pipe.sv
// decoder_pipe: pipelined one-hot/thermometer/inverted decoder with valid/ready skid buffer.
// Define DECODER_PIPE_STATS_EN to add saturating acc_cnt/stall_cnt outputs.
module decoder_pipe #(
  parameter int IN_W = 3,
  localparam int OUT_W = 2**IN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:IN_W-1]  din,
  input  logic [0:1]       mode,
  input  logic             en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:OUT_W-1] dout
`ifdef DECODER_PIPE_STATS_EN
  ,
  output logic [0:15]      acc_cnt,
  output logic [0:15]      stall_cnt
`endif
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state, state_nx;
  logic [OUT_W:0] one;
  logic [OUT_W-1:0] hot, therm, res, main, skid, main_nx;
  logic acc, pop, ld_main, ld_skid;
  assign acc = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign out_valid = state != EMPTY;
  assign dout = main;
  // decode at OUT_W+1 bits so the top thermometer index yields all ones
  always_comb begin
    one = (OUT_W+1)'(1) << din;
    hot = one[OUT_W-1:0];
    therm = OUT_W'((one << 1) - 1'b1);
    res = !en ? '0 :
          mode == 2'b00 ? hot :
          mode == 2'b01 ? therm :
          mode == 2'b10 ? ~hot : '0;
  end
  always_comb begin
    state_nx = state;
    ld_main = 1'b0;
    ld_skid = 1'b0;
    main_nx = res;
    case (state)
      EMPTY: if (acc) begin
        state_nx = ONE;
        ld_main = 1'b1;
      end
      ONE: if (acc && pop) ld_main = 1'b1;
      else if (acc) begin
        ld_skid = 1'b1;
        state_nx = FULL;
      end
      else if (pop) state_nx = EMPTY;
      FULL: if (pop) begin
        ld_main = 1'b1;
        main_nx = skid;
        state_nx = ONE;
      end
      default: state_nx = EMPTY;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= EMPTY;
      in_ready <= 1'b0;
      main <= '0;
      skid <= '0;
    end else begin
      state <= state_nx;
      in_ready <= state_nx != FULL;
      if (ld_main) main <= main_nx;
      if (ld_skid) skid <= res;
    end
`ifdef DECODER_PIPE_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (acc && acc_cnt != 16'hFFFF) acc_cnt <= acc_cnt + 16'd1;
      if (out_valid && !out_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_decoder_pipe.sv
// tb_decoder_pipe: directed self-checking bench for decoder_pipe at IN_W=3 and IN_W=6.
module tb_decoder_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic v3 = 1'b0, rdy3, ov3, ordy3 = 1'b1, en3 = 1'b1;
  logic [0:2] din3 = '0;
  logic [0:1] mode3 = '0;
  logic [0:7] dout3;
  logic v6 = 1'b0, rdy6, ov6, ordy6 = 1'b1, en6 = 1'b1;
  logic [0:5] din6 = '0;
  logic [0:1] mode6 = '0;
  logic [0:63] dout6;
  int checks = 0;
  int errors = 0;
`ifdef DECODER_PIPE_STATS_EN
  logic [0:15] acc3, stall3, acc6, stall6;
`endif
  always #5 clk = ~clk;
  decoder_pipe #(.IN_W(3)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(rdy3), .din(din3), .mode(mode3),
    .en(en3), .out_valid(ov3), .out_ready(ordy3), .dout(dout3)
`ifdef DECODER_PIPE_STATS_EN
    , .acc_cnt(acc3), .stall_cnt(stall3)
`endif
  );
  decoder_pipe #(.IN_W(6)) u6 (
    .clk(clk), .rst_n(rst_n), .in_valid(v6), .in_ready(rdy6), .din(din6), .mode(mode6),
    .en(en6), .out_valid(ov6), .out_ready(ordy6), .dout(dout6)
`ifdef DECODER_PIPE_STATS_EN
    , .acc_cnt(acc6), .stall_cnt(stall6)
`endif
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic send3(input string tag, input logic [2:0] d, input logic [1:0] m, input logic e, input logic [7:0] exp);
    v3 = 1'b1; din3 = d; mode3 = m; en3 = e;
    step();
    v3 = 1'b0;
    chk({tag, "_ov"}, 64'(ov3), 64'd1);
    chk(tag, 64'(dout3), 64'(exp));
    step();
    chk({tag, "_pop"}, 64'(ov3), 64'd0);
  endtask
  task automatic send6(input string tag, input logic [5:0] d, input logic [1:0] m, input logic [63:0] exp);
    v6 = 1'b1; din6 = d; mode6 = m; en6 = 1'b1;
    step();
    v6 = 1'b0;
    chk(tag, dout6, exp);
    step();
  endtask
  initial begin
    #3;
    chk("rst_ov", 64'(ov3), 64'd0);
    chk("rst_rdy", 64'(rdy3), 64'd0);
    chk("rst_dout", 64'(dout3), 64'd0);
    #9 rst_n = 1'b1;
    step();
    chk("rel_rdy", 64'(rdy3), 64'd1);
    send3("oh5", 3'd5, 2'b00, 1'b1, 8'h20);
    send3("oh3", 3'd3, 2'b00, 1'b1, 8'h08);
    send3("th3", 3'd3, 2'b01, 1'b1, 8'h0F);
    send3("inv3", 3'd3, 2'b10, 1'b1, 8'hF7);
    send3("res3", 3'd3, 2'b11, 1'b1, 8'h00);
    send3("en0", 3'd3, 2'b01, 1'b0, 8'h00);
    send3("th7", 3'd7, 2'b01, 1'b1, 8'hFF);
    send3("inv0", 3'd0, 2'b10, 1'b1, 8'hFE);
    send3("oh7", 3'd7, 2'b00, 1'b1, 8'h80);
    send3("th0", 3'd0, 2'b01, 1'b1, 8'h01);
    // backpressure fills main then skid; a request presented while full must be ignored
    ordy3 = 1'b0; mode3 = 2'b00; en3 = 1'b1;
    v3 = 1'b1; din3 = 3'd1;
    step();
    chk("bp_rdy1", 64'(rdy3), 64'd1);
    din3 = 3'd2;
    step();
    din3 = 3'd7;
    chk("bp_full_rdy", 64'(rdy3), 64'd0);
    chk("bp_dout", 64'(dout3), 64'h02);
    step();
    chk("bp_hold", 64'(dout3), 64'h02);
    chk("bp_hold_ov", 64'(ov3), 64'd1);
    v3 = 1'b0; ordy3 = 1'b1;
    step();
    chk("bp_pop2", 64'(dout3), 64'h04);
    chk("bp_rdy_back", 64'(rdy3), 64'd1);
    step();
    chk("bp_empty", 64'(ov3), 64'd0);
    v3 = 1'b1; din3 = 3'd1;
    step();
    din3 = 3'd6;
    step();
    v3 = 1'b0;
    chk("sim_dout", 64'(dout3), 64'h40);
    chk("sim_ov", 64'(ov3), 64'd1);
    chk("sim_rdy", 64'(rdy3), 64'd1);
    step();
    chk("sim_empty", 64'(ov3), 64'd0);
    ordy3 = 1'b0; v3 = 1'b1; din3 = 3'd1;
    step();
    din3 = 3'd2;
    step();
    v3 = 1'b0;
    chk("pre_rst_full", 64'(rdy3), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ov", 64'(ov3), 64'd0);
    chk("arst_dout", 64'(dout3), 64'd0);
    chk("arst_rdy", 64'(rdy3), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    step();
    chk("arel_rdy", 64'(rdy3), 64'd1);
    chk("arel_ov", 64'(ov3), 64'd0);
    ordy3 = 1'b1;
    send3("arst_oh0", 3'd0, 2'b00, 1'b1, 8'h01);
    send6("w_oh63", 6'd63, 2'b00, 64'h8000_0000_0000_0000);
    send6("w_th63", 6'd63, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF);
    send6("w_inv0", 6'd0, 2'b10, 64'hFFFF_FFFF_FFFF_FFFE);
    send6("w_th31", 6'd31, 2'b01, 64'h0000_0000_FFFF_FFFF);
`ifdef DECODER_PIPE_STATS_EN
    chk("acc6_4", 64'(acc6), 64'd4);
    chk("stall6_0", 64'(stall6), 64'd0);
    chk("acc3_1", 64'(acc3), 64'd1);
    ordy6 = 1'b0; v6 = 1'b1; din6 = 6'd1;
    step();
    v6 = 1'b0;
    step(); step(); step();
    chk("stall6_3", 64'(stall6), 64'd3);
    ordy6 = 1'b1;
    step();
    v6 = 1'b1;
    for (int i = 0; i < 70000; i++) step();
    v6 = 1'b0;
    chk("acc6_sat", 64'(acc6), 64'hFFFF);
    chk("stall6_keep", 64'(stall6), 64'd3);
    step();
    chk("acc6_hold", 64'(acc6), 64'hFFFF);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/decoder_pipe.md
Name: decoder_pipe

Overview:
- Parametrised, pipelined successor to the fixed 2-to-4 and 3-to-8 combinational decoders.
- Decodes an IN_W-bit index into a 2**IN_W-bit vector in one of three run-time modes: one-hot, thermometer or inverted one-hot.
- Carries each request through a valid/ready handshake with a 2-entry skid buffer, so it can sit between pipeline stages (e.g. register-file write-enable or SPR select generation) without combinational ready paths.

Parameters:
- IN_W, 3, index width; legal range 1..6.
- OUT_W, 2**IN_W, derived localparam, not overridable; output vector width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request; registered output.
- din  in  [0:IN_W-1]  binary index; bit 0 is the MSB.
- mode  in  [0:1]  decode mode, sampled with din.
- en  in  1  sampled with din; 0 forces an all-zero result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- dout  out  [0:OUT_W-1]  decoded vector, registered.

Behaviour:
- Bit numbering:
  - dout as an unsigned number equals (1 << din) in one-hot mode.
  - The set bit is therefore dout[OUT_W-1-din]; din=0 sets the rightmost bit, matching the existing decoders.
- Decode function f(din, mode, en):
  - en=0 -> all zeros, for any mode.
  - mode 00, one-hot -> 1 << din.
  - mode 01, thermometer -> (2 << din) - 1, i.e. bits for indices 0..din set; din=OUT_W-1 gives all ones. Compute at OUT_W+1 bits and truncate.
  - mode 10, inverted one-hot -> ~(1 << din).
  - mode 11, reserved -> all zeros.
- Datapath: two registers, main (drives dout/out_valid) and skid.
- Accept: a request is accepted when in_valid && in_ready. f() is computed on the input side and stored; neither register stores din.
- Latency: accepted request appears on dout at the next rising edge when main is empty, or frees up on the same edge.
- Occupancy states:
  - EMPTY:
    - out_valid=0, in_ready=1.
    - accept -> ONE.
  - ONE:
    - out_valid=1, in_ready=1.
    - accept and no pop -> write skid, go to FULL.
    - pop and no accept -> EMPTY.
    - accept and pop in the same cycle -> main reloads with the new result, stay ONE.
  - FULL:
    - out_valid=1, in_ready=0.
    - pop -> main <= skid, go to ONE.
    - in_valid is ignored.
- Pop: out_valid && out_ready.
- Ordering: strict FIFO; results never reorder or duplicate.
- Stability: dout and out_valid hold stable while out_valid=1 and out_ready=0.
- in_ready is a registered function of occupancy only: high in EMPTY/ONE, low in FULL. No combinational path from out_ready to in_ready.
- Reset (asserted asynchronously, any time including mid-transfer):
  - state EMPTY.
  - out_valid=0, in_ready=0 while rst_n low, in_ready=1 from the first clock after release.
  - dout=0, skid=0.
  - Pending data is discarded.
- X-safety: din/mode/en are don't-care when in_valid=0; no register captures them then.

Optional Feature:
- Macro: DECODER_PIPE_STATS_EN.
- When defined, add two output ports:
  - acc_cnt [0:15]: saturating count of accepted requests.
  - stall_cnt [0:15]: saturating count of cycles with out_valid=1 && out_ready=0.
- Both counters reset to 0 under rst_n, saturate at 16'hFFFF (no wrap) and increment at most once per cycle.
- When undefined, the ports and counters do not exist; remaining behaviour is identical.

Test Plan:
- IN_W=3, mode 00, en=1, din=5, out_ready=1 -> next cycle out_valid=1, dout=8'h20; following cycle out_valid=0.
- IN_W=3, sweep all modes with din=3:
  - 00 -> 8'h08.
  - 01 -> 8'h0F.
  - 10 -> 8'hF7.
  - 11 -> 8'h00.
  - en=0 with mode 01 -> 8'h00.
  - Edge cases: din=7, mode 01 -> 8'hFF; din=0, mode 10 -> 8'hFE.
- Backpressure: out_ready=0, send din=1 then din=2 -> in_ready drops after the second accept; dout holds 8'h02. Raise out_ready -> pops 8'h02 then 8'h04 in order, in_ready returns high.
- Simultaneous: in ONE state, accept din=6 while popping -> stays ONE, dout=8'h40 next cycle, in_ready stays 1.
- Reset mid-operation: FULL state, assert rst_n low asynchronously between edges -> out_valid=0, dout=0 immediately; after release the first accept of din=0 gives dout=8'h01.
- IN_W=6 with DECODER_PIPE_STATS_EN: 70000 back-to-back accepts -> acc_cnt=16'hFFFF; din=63, mode 00 -> dout MSB-only pattern 64'h8000_0000_0000_0000.
